md_unit: RTL and testbench
==========================

# md_unit

Parametrised multiply/divide execute unit that adds the RV32M/RV64M instruction group to the five-stage pipeline. It sits beside the ALU in the E stage and takes the already-forwarded source operands. It computes iteratively, one bit per cycle, and holds the front of the pipeline through a combinational stall request until its result is ready. The result is then presented for one cycle so the instruction can advance into the E/M pipeline register.

## Interface
- XLEN, default 32: operand/result width. Must be a power of two, ≥ 8.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  E-stage instruction is an M-extension op; sampled only in IDLE.
- funct3  in  3  operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  in  XLEN  forwarded rs1 value (SrcA).
- op_b  in  XLEN  forwarded rs2 value (SrcB).
- flush  in  1  kill the in-flight operation; driven by FlushE.
- stall  out  1  combinational stall request to the hazard unit (StallF/StallD, hold E).
- done  out  1  registered one-cycle pulse; result valid.
- result  out  XLEN  registered result.

## Operation
- Three-state FSM:
  - IDLE: waiting for start.
  - CALC: iterating.
  - DONE: result presented.
- IDLE → CALC when start=1 and flush=0.
  - Latch funct3, |op_a|, |op_b| and sign flags.
  - Clear the accumulator and load the iteration counter with XLEN. The counter is clog2(XLEN)+1 bits wide.
- Signedness:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: op_a signed, op_b unsigned.
  - MULHU/DIVU/REMU: both unsigned.
- Multiply: shift-add on magnitudes into a 2·XLEN product.
  - Product is negated if sign_a XOR sign_b, counting only signed operands.
  - MUL returns product[XLEN-1:0]. MULH/MULHSU/MULHU return product[2XLEN-1:XLEN].
- Divide: restoring shift-subtract on magnitudes, one quotient bit per cycle.
  - Quotient is negated if sign_a XOR sign_b.
  - Remainder takes the sign of op_a.
- The result register is written on the CALC → DONE edge, with sign fix-up applied combinationally from the final accumulator.
- Special cases go IDLE → DONE directly, with no iterations:
  - Divide by zero (op_b=0): DIV/DIVU return all-ones; REM/REMU return op_a.
  - Signed overflow (DIV/REM, op_a = 1 followed by XLEN-1 zeros, op_b = all-ones): DIV returns op_a; REM returns 0.
- DONE → IDLE unconditionally. start is ignored in DONE, so the same instruction does not retrigger.
- stall = (state==IDLE & start & ~flush) | (state==CALC).
- stall is low in DONE and in IDLE without start.
- result holds its value until the next entry into DONE.
- flush in any state: go to IDLE next edge, no done, result unchanged. flush wins over a simultaneous start.
- rst at any point, including mid-CALC: state IDLE, done=0, result=0, counter=0, accumulators=0.

## Timing
- Reset values: stall=0 (with start=0), done=0, result=0.
- Normal op with start in cycle T:
  - stall=1 in cycles T … T+XLEN.
  - CALC occupies cycles T+1 … T+XLEN.
  - done=1, stall=0, result valid in cycle T+XLEN+1.
  - Total latency is XLEN+1 cycles (33 for XLEN=32).
- Special case with start in cycle T: stall=1 in T only; done=1 in T+1.
- Back-to-back M ops: the next start is accepted no earlier than T+XLEN+2 (IDLE), because the instruction advances out of E in the DONE cycle.
- done is never asserted for two consecutive cycles.

## Test plan (XLEN=32)
- MUL, a=7, b=0xFFFFFFFD, start at T → stall high T..T+32; done at T+33; result=0xFFFFFFEB.
- High products:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Division:
  - DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD.
  - REM 0xFFFFFFF9 / 2 → 0xFFFFFFFF.
  - DIVU 100 / 7 → 14; REMU 100 / 7 → 2.
  - Each completes at T+33.
- Divide by zero:
  - DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5.
  - Both with done at T+1 and stall only in T.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0; done at T+1.
- Flush and reset:
  - Flush at T+10 → no done, stall=0 from T+11, result unchanged.
  - New start at T+12 → done at T+45.
  - rst at T+5 → all outputs 0 in T+6 and no done afterwards.
  - start asserted with flush=1 → ignored.

Source files
------------

// File: rtl/md_unit.sv
// Iterative RV32M/RV64M multiply/divide unit for the E stage: one bit per cycle,
// combinational stall to the hazard unit, registered one-cycle done pulse with result.
module md_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state, state_nxt;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   mag_b;
  logic [XLEN:0]     acc_hi;
  logic [XLEN-1:0]   acc_lo;
  logic [CW-1:0]     count;
  logic              neg_main, neg_rem;

  logic              a_signed, b_signed, sign_a, sign_b;
  logic [XLEN-1:0]   mag_a_in, mag_b_in;
  logic              div0, ovf, special;
  logic [XLEN-1:0]   special_res;

  logic [XLEN:0]     mul_sum, rem_shift, diff;
  logic [XLEN:0]     acc_hi_nxt;
  logic [XLEN-1:0]   acc_lo_nxt;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, calc_res;

  // Operand decode for the incoming instruction; signed views come from funct3.
  always_comb begin
    a_signed = ~((funct3 == 3'b011) | (funct3 == 3'b101) | (funct3 == 3'b111));
    b_signed = (funct3 == 3'b000) | (funct3 == 3'b001) |
               (funct3 == 3'b100) | (funct3 == 3'b110);
    sign_a   = a_signed & op_a[XLEN-1];
    sign_b   = b_signed & op_b[XLEN-1];
    mag_a_in = sign_a ? (~op_a + 1'b1) : op_a;
    mag_b_in = sign_b ? (~op_b + 1'b1) : op_b;
    div0     = funct3[2] & (op_b == '0);
    ovf      = funct3[2] & ~funct3[0] & (op_a == MIN_NEG) & (op_b == '1);
    special  = div0 | ovf;
    special_res = '0;
    if (div0)
      special_res = funct3[1] ? op_a : '1;
    else if (ovf)
      special_res = funct3[1] ? '0 : op_a;
  end

  // One iteration: shift-add for multiply, restoring shift-subtract for divide.
  always_comb begin
    mul_sum   = acc_hi + {1'b0, (acc_lo[0] ? mag_b : {XLEN{1'b0}})};
    rem_shift = {acc_hi[XLEN-1:0], acc_lo[XLEN-1]};
    diff      = rem_shift - {1'b0, mag_b};
    if (op_q[2]) begin
      if (!diff[XLEN]) begin
        acc_hi_nxt = diff;
        acc_lo_nxt = {acc_lo[XLEN-2:0], 1'b1};
      end else begin
        acc_hi_nxt = rem_shift;
        acc_lo_nxt = {acc_lo[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_hi_nxt = {1'b0, mul_sum[XLEN:1]};
      acc_lo_nxt = {mul_sum[0], acc_lo[XLEN-1:1]};
    end
    prod     = {acc_hi_nxt[XLEN-1:0], acc_lo_nxt};
    prod_fix = neg_main ? (~prod + 1'b1) : prod;
    quo_fix  = neg_main ? (~acc_lo_nxt + 1'b1) : acc_lo_nxt;
    rem_fix  = neg_rem ? (~acc_hi_nxt[XLEN-1:0] + 1'b1) : acc_hi_nxt[XLEN-1:0];
    case (op_q)
      3'b000:                 calc_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: calc_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         calc_res = quo_fix;
      default:                calc_res = rem_fix;
    endcase
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        if (start && !flush) begin
          stall     = 1'b1;
          state_nxt = special ? DONE : CALC;
        end
      end
      CALC: begin
        stall = 1'b1;
        if (count == CW'(1))
          state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush)
      state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      done     <= 1'b0;
      result   <= '0;
      op_q     <= '0;
      mag_b    <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      count    <= '0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state_nxt == DONE);
      if (state == IDLE && start && !flush) begin
        op_q     <= funct3;
        mag_b    <= mag_b_in;
        acc_hi   <= '0;
        acc_lo   <= mag_a_in;
        count    <= CW'(XLEN);
        neg_main <= sign_a ^ sign_b;
        neg_rem  <= sign_a;
        if (special)
          result <= special_res;
      end else if (state == CALC && !flush) begin
        acc_hi <= acc_hi_nxt;
        acc_lo <= acc_lo_nxt;
        count  <= count - 1'b1;
        // Last iteration: the sign-fixed result is taken straight from the stepped accumulator.
        if (count == CW'(1))
          result <= calc_res;
      end
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit (XLEN=32): directed test-plan vectors, flush/reset
// scenarios and randomized ops against an arithmetic reference model.
module tb_md_unit;

  localparam int XLEN = 32;
  localparam logic [31:0] MIN_NEG = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic        flush;
  logic        stall, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_result;

  md_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .flush(flush),
    .stall(stall), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // Reference model straight from the RV32M arithmetic rules.
  function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub;
    longint unsigned ua, uub;
    logic [63:0] p;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'h0, b});
    ua = {32'h0, a};
    uub = {32'h0, b};
    ia = $signed(a);
    ib = $signed(b);
    p = '0;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * uub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MIN_NEG && b == 32'hFFFF_FFFF) return a;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN_NEG && b == 32'hFFFF_FFFF) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0 || (!f[0] && a == MIN_NEG && b == 32'hFFFF_FFFF)))
      return 1;
    return XLEN + 1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op in cycle T, track stall through CALC, and check latency/result/done pulse.
  task automatic applyStimulus(input string tag, input logic [2:0] f, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int lat;
    logic stall_gap;
    lat = 0;
    stall_gap = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; funct3 = f; op_a = a; op_b = b;
    @(negedge clk);
    checkOutput({tag, "_stall_T"}, 32'(stall), 32'd1);
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      if (done === 1'b1) begin
        lat = n;
        break;
      end
      if (stall !== 1'b1) stall_gap = 1'b1;
    end
    checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, "_stall_calc"}, 32'(stall_gap), 32'd0);
    checkOutput({tag, "_stall_done"}, 32'(stall), 32'd0);
    checkOutput({tag, "_result"}, result, exp_res);
    last_result = exp_res;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  task automatic watchNoDone(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done !== 1'b0) seen = 1'b1;
    end
    checkOutput({tag, "_no_done"}, 32'(seen), 32'd0);
  endtask

  initial begin
    logic [2:0]  rf;
    logic [31:0] ra, rb;
    int sel;

    rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
    last_result = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_stall", 32'(stall), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_result", result, 32'd0);

    applyStimulus("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    applyStimulus("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    applyStimulus("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    applyStimulus("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    applyStimulus("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    applyStimulus("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    applyStimulus("divu", 3'b101, 32'd100, 32'd7, 32'd14, 33);
    applyStimulus("remu", 3'b111, 32'd100, 32'd7, 32'd2, 33);
    applyStimulus("div_by0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    applyStimulus("rem_by0", 3'b110, 32'd5, 32'd0, 32'd5, 1);
    applyStimulus("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    applyStimulus("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);

    // Flush in T+10: no done, stall drops in T+11, result untouched; restart in T+12.
    @(posedge clk); #1;
    start = 1'b1; funct3 = 3'b000; op_a = 32'd12345; op_b = 32'd678;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    checkOutput("flush_stall", 32'(stall), 32'd0);
    checkOutput("flush_done", 32'(done), 32'd0);
    checkOutput("flush_result", result, last_result);
    applyStimulus("after_flush", 3'b101, 32'd1000, 32'd33, 32'd30, 33);

    // Start together with flush is ignored.
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; funct3 = 3'b000; op_a = 32'd3; op_b = 32'd3;
    @(negedge clk);
    checkOutput("startflush_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    watchNoDone("startflush", 40);
    checkOutput("startflush_result", result, last_result);

    // Reset in T+5 mid-CALC clears the outputs.
    @(posedge clk); #1;
    start = 1'b1; funct3 = 3'b001; op_a = 32'hDEAD_BEEF; op_b = 32'h1234_5678;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_stall", 32'(stall), 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    checkOutput("midrst_result", result, 32'd0);
    watchNoDone("midrst", 40);
    last_result = '0;

    for (int k = 0; k < 40; k++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) rb = 32'h0;
      else if (sel == 1) begin ra = MIN_NEG; rb = 32'hFFFF_FFFF; end
      else if (sel == 2) rb = 32'($urandom_range(1, 15));
      else if (sel == 3) ra = 32'($urandom_range(0, 255));
      applyStimulus("rand", rf, ra, rb, ref_md(rf, ra, rb), ref_latency(rf, ra, rb));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
